// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the floating-point multiply requester.
package fp_mul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    SERV  = 2'd3
  } req_state_t;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
  } fp_pair_t;

endpackage

// File: rtl/fp_pair_fifo.sv
// Operand-pair queue: DEPTH entries of fp_pair_t with wrapping pointers.
// Latency: a push is visible at the head one cycle later; the head is read combinationally.
// Backpressure: the caller must not push when full or pop when empty.
module fp_pair_fifo
  import fp_mul_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       push,
  input  logic                       pop,
  input  fp_pair_t                   wr_data,
  output fp_pair_t                   rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  fp_pair_t      mem [DEPTH];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/fp_mul_requester.sv
// Queues operand pairs, issues them one at a time to the multiplier and returns each product.
// Latency: accept-to-issue 1 cycle; result registered 1 cycle after mul_done (or timeout).
// Backpressure: in_ready low when queue full; a busy output slot holds the FSM in WAIT.
module fp_mul_requester
  import fp_mul_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_op1,
  input  logic [31:0]                in_op2,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_result,
  output logic                       out_timeout,
  output logic [$clog2(DEPTH+1)-1:0] pending,
  output logic                       mul_start,
  output logic [31:0]                mul_op1,
  output logic [31:0]                mul_op2,
  input  logic                       mul_busy,
  input  logic                       mul_done,
  input  logic [31:0]                mul_result,
  output logic                       mul_serv
);

  localparam int            TW     = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  req_state_t    state;
  req_state_t    state_nxt;
  logic [TW-1:0] tmo_cnt;

  fp_pair_t wr_pair;
  fp_pair_t head;
  logic     q_full;
  logic     q_empty;
  logic     push;
  logic     pop;

  logic slot_free;
  logic can_issue;
  logic cap_done;
  logic cap_tmo;
  logic capture;
  logic load_ops;

  assign wr_pair  = '{op1: in_op1, op2: in_op2};
  assign in_ready = !q_full;
  assign push     = in_valid && !q_full;
  assign pop      = (state == ISSUE);

  fp_pair_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_pair),
    .rd_data (head),
    .full    (q_full),
    .empty   (q_empty),
    .count   (pending)
  );

  assign slot_free = !out_valid || out_ready;
  assign can_issue = !q_empty && !mul_busy;
  assign cap_done  = (state == WAIT) && mul_done && slot_free;
  assign cap_tmo   = (state == WAIT) && !mul_done && (tmo_cnt == T_LAST) && slot_free;
  assign capture   = cap_done || cap_tmo;
  assign load_ops  = (state_nxt == ISSUE) && (state != ISSUE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (can_issue) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (capture) state_nxt = SERV;
      SERV:    state_nxt = can_issue ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mul_start = (state == ISSUE);
    mul_serv  = (state == SERV);
  end

  // Operands stay stable from issue until the next pair is loaded.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mul_op1 <= '0;
      mul_op2 <= '0;
    end else if (load_ops) begin
      mul_op1 <= head.op1;
      mul_op2 <= head.op2;
    end
  end

  // Counter saturates at T_LAST so a blocked timeout waits for the slot without wrapping.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tmo_cnt <= '0;
    end else if (state == ISSUE) begin
      tmo_cnt <= '0;
    end else if ((state == WAIT) && !mul_done && (tmo_cnt != T_LAST)) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_timeout <= 1'b0;
    end else if (capture) begin
      out_valid   <= 1'b1;
      out_result  <= cap_done ? mul_result : FP_QNAN;
      out_timeout <= cap_tmo;
    end else if (out_valid && out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp_mul_requester.sv
// Directed/randomised bench for fp_mul_requester with a behavioural multiplier and IEEE reference.
module tb_fp_mul_requester;

  localparam int          DEPTH   = 4;
  localparam int          TIMEOUT = 64;
  localparam int          LAT     = 3;
  localparam logic [31:0] QNAN    = 32'h7FC00000;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    bit          hang;
  } iss_t;

  typedef struct {
    logic [31:0] res;
    logic        tmo;
  } res_t;

  logic clk, n_rst;
  logic in_valid, in_ready, out_valid, out_ready, out_timeout;
  logic [31:0] in_op1, in_op2, out_result, mul_op1, mul_op2, mul_result;
  logic [$clog2(DEPTH+1)-1:0] pending;
  logic mul_start, mul_busy, mul_done, mul_serv;
  logic force_busy, model_busy;

  assign mul_busy = force_busy | model_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_start = 0;
  int n_serv = 0;
  int rcv_cnt = 0;
  int lat_cnt = 0;
  iss_t        iss_q[$];
  res_t        res_q[$];
  int          start_q[$];
  int          lat_q[$];
  logic [31:0] got_q[$];
  iss_t        cur;

  fp_mul_requester #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op1     (in_op1),
    .in_op2     (in_op2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_timeout(out_timeout),
    .pending    (pending),
    .mul_start  (mul_start),
    .mul_op1    (mul_op1),
    .mul_op2    (mul_op2),
    .mul_busy   (mul_busy),
    .mul_done   (mul_done),
    .mul_result (mul_result),
    .mul_serv   (mul_serv)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Single-precision product of two normal operands, round to nearest even.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] ma, mb, p;
    logic [23:0] m;
    logic        g, s;
    int          e;
    ma = {24'd0, 1'b1, a[22:0]};
    mb = {24'd0, 1'b1, b[22:0]};
    p  = ma * mb;
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[47:24]; g = p[23]; s = |p[22:0]; e = e + 1;
    end else begin
      m = p[46:23]; g = p[22]; s = |p[21:0];
    end
    if (g && (s || m[0])) begin
      m = m + 24'd1;
      if (m == 24'd0) begin
        m = 24'h800000; e = e + 1;
      end
    end
    return {a[31] ^ b[31], 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    return {1'($urandom_range(1, 0)), 8'($urandom_range(150, 100)), 23'($urandom)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_true(input string tag, input logic cond);
    checks++;
    assert (cond === 1'b1) else begin
      errors++;
      $error("FAIL %s observed=%b expected=1", tag, cond);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input bit hang);
    int n;
    step();
    in_valid = 1'b1; in_op1 = a; in_op2 = b;
    n = 0;
    while (!in_ready && n < 500) begin
      step();
      n++;
    end
    chk_true("send_accepted", in_ready);
    step();
    in_valid = 1'b0;
    iss_q.push_back('{op1: a, op2: b, hang: hang});
    if (hang) res_q.push_back('{res: QNAN, tmo: 1'b1});
    else      res_q.push_back('{res: fmul(a, b), tmo: 1'b0});
  endtask

  task automatic wait_rcv(input int tgt, input int budget);
    int n;
    n = 0;
    while (rcv_cnt < tgt && n < budget) begin
      step();
      n++;
    end
    chk_true("results_within_budget", rcv_cnt >= tgt);
  endtask

  // Behavioural multiplier plus result scoreboard, all sampled mid-cycle.
  initial begin
    res_t r;
    model_busy = 1'b0; mul_done = 1'b0; mul_result = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mul_start) n_start++;
      if (!n_rst) begin
        model_busy = 1'b0; mul_done = 1'b0; lat_cnt = 0;
        start_q.delete();
      end else begin
        if (mul_start) begin
          chk("start_not_busy", 32'(mul_busy), 32'd0);
          chk_true("start_has_pair", iss_q.size() != 0);
          if (iss_q.size() != 0) begin
            cur = iss_q.pop_front();
            chk("mul_op1_issue", mul_op1, cur.op1);
            chk("mul_op2_issue", mul_op2, cur.op2);
            start_q.push_back(cyc);
            if (!cur.hang) begin
              model_busy = 1'b1;
              lat_cnt    = LAT;
            end
          end
        end else if (lat_cnt != 0) begin
          lat_cnt--;
          if (lat_cnt == 0) begin
            chk("mul_op1_held", mul_op1, cur.op1);
            model_busy = 1'b0;
            mul_done   = 1'b1;
            mul_result = fmul(cur.op1, cur.op2);
          end
        end
        if (mul_serv) begin
          n_serv++;
          mul_done = 1'b0;
        end
        if (out_valid && out_ready) begin
          rcv_cnt++;
          got_q.push_back(out_result);
          chk_true("result_expected", res_q.size() != 0);
          if (res_q.size() != 0) begin
            r = res_q.pop_front();
            chk("out_result", out_result, r.res);
            chk("out_timeout", 32'(out_timeout), 32'(r.tmo));
          end
          if (start_q.size() != 0) lat_q.push_back(cyc - start_q.pop_front());
        end
      end
    end
  end

  initial begin
    int base, snap, n, lat;
    logic [31:0] first_exp;
    n_rst = 1'b0; in_valid = 1'b1; in_op1 = 32'h3F800000; in_op2 = 32'h40000000;
    out_ready = 1'b1; force_busy = 1'b0;

    // Reset held with an offered pair.
    repeat (4) step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_timeout", 32'(out_timeout), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_mul_op1", mul_op1, 32'd0);
    chk("rst_mul_serv", 32'(mul_serv), 32'd0);
    chk("rst_no_start", 32'(n_start), 32'd0);
    in_valid = 1'b0;
    step();
    n_rst = 1'b1;
    step();

    // Single pair: 1.25 * 1.5.
    send(32'h3FA00000, 32'h3FC00000, 1'b0);
    wait_rcv(1, 50);
    chk("single_result", out_result, 32'h3FF00000);
    chk("single_timeout", 32'(out_timeout), 32'd0);
    chk("single_starts", 32'(n_start), 32'd1);
    chk("single_servs", 32'(n_serv), 32'd1);
    chk_true("single_lat_seen", lat_q.size() != 0);
    if (lat_q.size() != 0) begin
      lat = lat_q.pop_front();
      chk("single_latency", 32'(lat), 32'(LAT + 1));
    end

    // Fill the queue while the multiplier reports busy.
    base = rcv_cnt;
    snap = n_start;
    force_busy = 1'b1;
    send(32'h40000000, 32'h40400000, 1'b0);
    send(32'h3F800000, 32'hC0C00000, 1'b0);
    send(32'hC0400000, 32'hC0800000, 1'b0);
    send(32'h3F490FDB, 32'h3F490FDB, 1'b0);
    step();
    chk("full_pending", 32'(pending), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_op1 = rnd_op(); in_op2 = rnd_op();
    repeat (3) step();
    chk("fifth_in_ready", 32'(in_ready), 32'd0);
    chk("fifth_pending", 32'(pending), 32'd4);
    chk("busy_no_start", 32'(n_start), 32'(snap));
    in_valid = 1'b0;
    force_busy = 1'b0;
    send(rnd_op(), rnd_op(), 1'b0);
    wait_rcv(base + 5, 300);
    chk_true("order_count", got_q.size() >= base + 3);
    if (got_q.size() >= base + 3) begin
      chk("order_0", got_q[base], 32'h40C00000);
      chk("order_1", got_q[base + 1], 32'hC0C00000);
      chk("order_2", got_q[base + 2], 32'h41400000);
    end

    // Output stall: a finished product must wait without timing out.
    base = rcv_cnt;
    out_ready = 1'b0;
    send(rnd_op(), rnd_op(), 1'b0);
    send(rnd_op(), rnd_op(), 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    chk_true("stall_first_valid", out_valid);
    first_exp = (res_q.size() != 0) ? res_q[0].res : 32'hX;
    repeat (2) step();
    snap = n_serv;
    repeat (100) step();
    chk("stall_no_serv", 32'(n_serv), 32'(snap));
    chk("stall_held_valid", 32'(out_valid), 32'd1);
    chk("stall_held_result", out_result, first_exp);
    chk("stall_no_timeout", 32'(out_timeout), 32'd0);
    out_ready = 1'b1;
    wait_rcv(base + 2, 50);

    // Multiplier that never answers, followed by a normal pair.
    base = rcv_cnt;
    snap = n_serv;
    lat_q.delete();
    send(rnd_op(), rnd_op(), 1'b1);
    send(rnd_op(), rnd_op(), 1'b0);
    wait_rcv(base + 2, 400);
    chk("tmo_servs", 32'(n_serv), 32'(snap + 2));
    chk_true("tmo_lat_seen", lat_q.size() != 0);
    if (lat_q.size() != 0) begin
      lat = lat_q.pop_front();
      chk("tmo_latency", 32'(lat), 32'(TIMEOUT + 1));
    end
    chk_true("tmo_value_seen", got_q.size() > base);
    if (got_q.size() > base) chk("tmo_value", got_q[base], QNAN);

    // Reset in WAIT with two pairs queued.
    send(rnd_op(), rnd_op(), 1'b1);
    send(rnd_op(), rnd_op(), 1'b0);
    send(rnd_op(), rnd_op(), 1'b0);
    repeat (2) step();
    chk("prerst_pending", 32'(pending), 32'd2);
    #2;
    n_rst = 1'b0;
    #1;
    chk("midrst_pending", 32'(pending), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_result", out_result, 32'd0);
    chk("midrst_mul_start", 32'(mul_start), 32'd0);
    chk("midrst_mul_op1", mul_op1, 32'd0);
    chk("midrst_mul_op2", mul_op2, 32'd0);
    iss_q.delete();
    res_q.delete();
    repeat (3) step();
    n_rst = 1'b1;
    snap = n_start;
    repeat (20) step();
    chk("postrst_no_issue", 32'(n_start), 32'(snap));
    base = rcv_cnt;
    send(rnd_op(), rnd_op(), 1'b0);
    wait_rcv(base + 1, 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
